// File: rtl/pe_pkg.sv
// Shared constants and helpers for the motion-estimation datapath.
// Used by the SAD row, the line buffers and the MV decision logic.
package pe_pkg;

    localparam int unsigned DEF_PIX_W   = 8;
    localparam int unsigned DEF_NUM_PE  = 16;
    localparam int unsigned DEF_MAX_LEN = 256;
    localparam int unsigned DEF_ACC_W   = 16;

    // Working width of sat_add; callers cast operands in and the result out.
    localparam int unsigned SAT_W  = 32;
    localparam int unsigned SAT_W1 = SAT_W + 1;

    // a + b clamped to 2^w - 1 (w <= SAT_W - 1).
    function automatic logic [SAT_W-1:0] sat_add(
        input logic [SAT_W-1:0] a,
        input logic [SAT_W-1:0] b,
        input int unsigned      w
    );
        logic [SAT_W:0] sum;
        logic [SAT_W:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = SAT_W1'((64'(1) << w) - 64'(1));
        return (sum > lim) ? lim[SAT_W-1:0] : sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/pe_sad_cell.sv
// One SAD cell: current-pixel chain stage, previous-pixel stage 1 register,
// absolute difference and a saturating accumulator.
module pe_sad_cell
    import pe_pkg::*;
#(
    parameter int unsigned PIX_W = DEF_PIX_W,
    parameter int unsigned ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             crt_keep,
    input  logic [PIX_W-1:0] crt_i,
    input  logic [PIX_W-1:0] pre_i,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic [PIX_W-1:0] crt_o,
    output logic [ACC_W-1:0] sum_c
);

    logic [PIX_W-1:0] crt_q, crt_d;
    logic [PIX_W-1:0] pre_q, pre_d;
    logic [PIX_W-1:0] ad_c;
    logic [ACC_W-1:0] acc_q, acc_d;

    // Chain hold/shift, AD as larger minus smaller, clear beats accumulate.
    always_comb begin
        crt_d = crt_keep ? crt_q : crt_i;
        pre_d = pre_i;
        ad_c  = (crt_q >= pre_q) ? (crt_q - pre_q) : (pre_q - crt_q);
        sum_c = ACC_W'(sat_add(SAT_W'(acc_q), SAT_W'(ad_c), ACC_W));
        acc_d = acc_q;
        if (acc_clr) begin
            acc_d = '0;
        end else if (acc_en) begin
            acc_d = sum_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crt_q <= '0;
            pre_q <= '0;
            acc_q <= '0;
        end else begin
            crt_q <= crt_d;
            pre_q <= pre_d;
            acc_q <= acc_d;
        end
    end

    assign crt_o = crt_q;

endmodule

// File: rtl/pe_sad_row.sv
// Row of NUM_PE SAD cells with shared block-length control, a registered
// per-cell SAD output and a registered minimum finder (ties -> lowest index).
module pe_sad_row
    import pe_pkg::*;
#(
    parameter  int unsigned PIX_W   = DEF_PIX_W,
    parameter  int unsigned NUM_PE  = DEF_NUM_PE,
    parameter  int unsigned MAX_LEN = DEF_MAX_LEN,
    parameter  int unsigned ACC_W   = DEF_ACC_W,
    localparam int unsigned IDX_W   = $clog2(NUM_PE),
    localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    crt_keep,
    input  logic [PIX_W-1:0]        crt_pixel_i,
    input  logic [NUM_PE*PIX_W-1:0] pre_pixel_i,
    input  logic                    in_valid,
    input  logic [CNT_W-1:0]        acc_len,
    input  logic                    flush,
    output logic [PIX_W-1:0]        crt_pixel_o,
    output logic [NUM_PE*ACC_W-1:0] sad_o,
    output logic                    sad_valid,
    output logic [ACC_W-1:0]        min_sad,
    output logic [IDX_W-1:0]        min_idx,
    output logic                    min_valid,
    output logic                    busy
);

    localparam int unsigned TREE_N = 32'd1 << IDX_W;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             v1_q, v1_d;
    logic             sad_valid_q, sad_valid_d;
    logic             min_valid_q, min_valid_d;
    logic             busy_q, busy_d;
    logic [ACC_W-1:0] min_sad_q, min_sad_d;
    logic [IDX_W-1:0] min_idx_q, min_idx_d;
    logic [ACC_W-1:0] sad_q [NUM_PE];
    logic [ACC_W-1:0] sad_d [NUM_PE];

    logic [ACC_W-1:0] sum_w [NUM_PE];
    logic [PIX_W-1:0] crt_w [NUM_PE];
    logic [CNT_W-1:0] len_new_c;
    logic [CNT_W-1:0] len_cur_c;
    logic             last_c;
    logic             acc_en_c;
    logic             acc_clr_c;
    logic [ACC_W-1:0] tree_sad_c;
    logic [IDX_W-1:0] tree_idx_c;

    // Cells; the current-pixel chain runs from cell 0 towards cell NUM_PE-1.
    for (genvar k = 0; k < NUM_PE; k++) begin : g_cell
        logic [PIX_W-1:0] chain_in;
        if (k == 0) begin : g_head
            assign chain_in = crt_pixel_i;
        end else begin : g_link
            assign chain_in = crt_w[k-1];
        end

        pe_sad_cell #(
            .PIX_W (PIX_W),
            .ACC_W (ACC_W)
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .crt_keep (crt_keep),
            .crt_i    (chain_in),
            .pre_i    (pre_pixel_i[k*PIX_W +: PIX_W]),
            .acc_en   (acc_en_c),
            .acc_clr  (acc_clr_c),
            .crt_o    (crt_w[k]),
            .sum_c    (sum_w[k])
        );

        assign sad_o[k*ACC_W +: ACC_W] = sad_q[k];
    end

    // Block length for the current beat: fresh on the first beat, latched after.
    always_comb begin
        if (acc_len == '0) begin
            len_new_c = CNT_W'(1);
        end else if (acc_len > CNT_W'(MAX_LEN)) begin
            len_new_c = CNT_W'(MAX_LEN);
        end else begin
            len_new_c = acc_len;
        end
        len_cur_c = (cnt_q == '0) ? len_new_c : len_q;
        last_c    = v1_q && !flush && ((cnt_q + CNT_W'(1)) == len_cur_c);
        acc_en_c  = v1_q && !flush;
        acc_clr_c = flush || last_c;
    end

    // Beat counter, block end and SAD capture; flush outranks block end.
    always_comb begin
        cnt_d       = cnt_q;
        len_d       = len_q;
        v1_d        = flush ? 1'b0 : in_valid;
        sad_valid_d = last_c;
        min_valid_d = sad_valid_q;
        min_sad_d   = min_sad_q;
        min_idx_d   = min_idx_q;
        for (int k = 0; k < NUM_PE; k++) begin
            sad_d[k] = last_c ? sum_w[k] : sad_q[k];
        end

        if (flush) begin
            cnt_d = '0;
        end else if (v1_q) begin
            if (cnt_q == '0) begin
                len_d = len_new_c;
            end
            cnt_d = last_c ? '0 : (cnt_q + CNT_W'(1));
        end
        busy_d = (cnt_d != '0);

        if (sad_valid_q) begin
            min_sad_d = tree_sad_c;
            min_idx_d = tree_idx_c;
        end
    end

    // Pairwise min reduction over sad_q; padded leaves hold all-ones.
    for (genvar l = 0; l <= IDX_W; l++) begin : g_lvl
        localparam int unsigned NODES = TREE_N >> l;
        logic [ACC_W-1:0] s [NODES];
        logic [IDX_W-1:0] i [NODES];
        for (genvar n = 0; n < NODES; n++) begin : g_node
            if (l == 0) begin : g_leaf
                if (n < NUM_PE) begin : g_real
                    assign s[n] = sad_q[n];
                end else begin : g_pad
                    assign s[n] = '1;
                end
                assign i[n] = IDX_W'(n);
            end else begin : g_pair
                logic take_r;
                assign take_r = g_lvl[l-1].s[2*n+1] < g_lvl[l-1].s[2*n];
                assign s[n]   = take_r ? g_lvl[l-1].s[2*n+1] : g_lvl[l-1].s[2*n];
                assign i[n]   = take_r ? g_lvl[l-1].i[2*n+1] : g_lvl[l-1].i[2*n];
            end
        end
    end

    assign tree_sad_c = g_lvl[IDX_W].s[0];
    assign tree_idx_c = g_lvl[IDX_W].i[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            len_q       <= '0;
            v1_q        <= 1'b0;
            sad_valid_q <= 1'b0;
            min_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            min_sad_q   <= '0;
            min_idx_q   <= '0;
            for (int k = 0; k < NUM_PE; k++) begin
                sad_q[k] <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            v1_q        <= v1_d;
            sad_valid_q <= sad_valid_d;
            min_valid_q <= min_valid_d;
            busy_q      <= busy_d;
            min_sad_q   <= min_sad_d;
            min_idx_q   <= min_idx_d;
            for (int k = 0; k < NUM_PE; k++) begin
                sad_q[k] <= sad_d[k];
            end
        end
    end

    assign crt_pixel_o = crt_w[NUM_PE-1];
    assign sad_valid   = sad_valid_q;
    assign min_valid   = min_valid_q;
    assign min_sad     = min_sad_q;
    assign min_idx     = min_idx_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_pe_sad_row.sv
// Directed bench for pe_sad_row: a 16-bit and a 12-bit accumulator instance
// share the same stimulus; expected values are hand-computed constants.
module tb_pe_sad_row;

    localparam int unsigned PIX_W   = 8;
    localparam int unsigned NUM_PE  = 16;
    localparam int unsigned MAX_LEN = 256;
    localparam int unsigned CNT_W   = 9;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned ACC_W   = 16;
    localparam int unsigned ACC_S   = 12;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    crt_keep;
    logic [PIX_W-1:0]        crt_pixel_i;
    logic [NUM_PE*PIX_W-1:0] pre_pixel_i;
    logic                    in_valid;
    logic [CNT_W-1:0]        acc_len;
    logic                    flush;

    logic [PIX_W-1:0]        crt_o16, crt_o12;
    logic [NUM_PE*ACC_W-1:0] sad_o16;
    logic [NUM_PE*ACC_S-1:0] sad_o12;
    logic                    sv16, sv12, mv16, mv12, busy16, busy12;
    logic [ACC_W-1:0]        min_sad16;
    logic [ACC_S-1:0]        min_sad12;
    logic [IDX_W-1:0]        min_idx16, min_idx12;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pe_sad_row #(.PIX_W(PIX_W), .NUM_PE(NUM_PE), .MAX_LEN(MAX_LEN), .ACC_W(ACC_W)) dut16 (
        .clk(clk), .rst(rst), .crt_keep(crt_keep), .crt_pixel_i(crt_pixel_i),
        .pre_pixel_i(pre_pixel_i), .in_valid(in_valid), .acc_len(acc_len), .flush(flush),
        .crt_pixel_o(crt_o16), .sad_o(sad_o16), .sad_valid(sv16), .min_sad(min_sad16),
        .min_idx(min_idx16), .min_valid(mv16), .busy(busy16)
    );

    pe_sad_row #(.PIX_W(PIX_W), .NUM_PE(NUM_PE), .MAX_LEN(MAX_LEN), .ACC_W(ACC_S)) dut12 (
        .clk(clk), .rst(rst), .crt_keep(crt_keep), .crt_pixel_i(crt_pixel_i),
        .pre_pixel_i(pre_pixel_i), .in_valid(in_valid), .acc_len(acc_len), .flush(flush),
        .crt_pixel_o(crt_o12), .sad_o(sad_o12), .sad_valid(sv12), .min_sad(min_sad12),
        .min_idx(min_idx12), .min_valid(mv12), .busy(busy12)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ACC_W-1:0] sad16(input int k);
        return sad_o16[k*ACC_W +: ACC_W];
    endfunction

    function automatic logic [ACC_S-1:0] sad12(input int k);
        return sad_o12[k*ACC_S +: ACC_S];
    endfunction

    task automatic set_pre_all(input int v);
        for (int k = 0; k < NUM_PE; k++) pre_pixel_i[k*PIX_W +: PIX_W] = PIX_W'(v);
    endtask

    task automatic fill_chain(input int v);
        crt_keep    = 1'b0;
        crt_pixel_i = PIX_W'(v);
        for (int j = 0; j < NUM_PE; j++) tick();
        crt_keep = 1'b1;
    endtask

    initial begin
        int pulses;
        int first_c;
        int second_c;
        int seen;

        rst = 1'b1; crt_keep = 1'b0; crt_pixel_i = '0; pre_pixel_i = '0;
        in_valid = 1'b0; acc_len = '0; flush = 1'b0;

        // Reset: everything observable is zero
        tick(); tick();
        chk("rst_sad_valid", 32'(sv16), 32'(0));
        chk("rst_min_valid", 32'(mv16), 32'(0));
        chk("rst_busy", 32'(busy16), 32'(0));
        chk("rst_crt_o", 32'(crt_o16), 32'(0));
        chk("rst_min_sad", 32'(min_sad16), 32'(0));
        chk("rst_min_idx", 32'(min_idx16), 32'(0));
        chk("rst_sad_o_any", 32'(|sad_o16), 32'(0));
        rst = 1'b0;

        // Chain fill with 0..15, then hold while the input changes
        crt_keep = 1'b0;
        for (int j = 0; j < NUM_PE; j++) begin
            crt_pixel_i = PIX_W'(j);
            tick();
        end
        crt_keep = 1'b1;
        chk("chain_crt_o", 32'(crt_o16), 32'(0));
        crt_pixel_i = 8'd99;
        tick(); tick();
        chk("chain_hold_crt_o", 32'(crt_o16), 32'(0));

        // With pre=0 and len 1, SAD of cell k equals crt_reg[k] = 15-k
        set_pre_all(0);
        acc_len  = 9'd1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("chain_sv_early", 32'(sv16), 32'(0));
        tick();
        chk("chain_sv", 32'(sv16), 32'(1));
        for (int k = 0; k < NUM_PE; k++) chk("chain_sad", 32'(sad16(k)), 32'(15 - k));
        tick();
        chk("chain_mv", 32'(mv16), 32'(1));
        chk("chain_sv_pulse", 32'(sv16), 32'(0));
        chk("chain_min_sad", 32'(min_sad16), 32'(0));
        chk("chain_min_idx", 32'(min_idx16), 32'(15));

        // Basic SAD: crt 100, pre 100+k, 4 beats -> 4k
        fill_chain(100);
        for (int k = 0; k < NUM_PE; k++) pre_pixel_i[k*PIX_W +: PIX_W] = PIX_W'(100 + k);
        acc_len  = 9'd4;
        in_valid = 1'b1;
        tick();
        chk("basic_busy_c1", 32'(busy16), 32'(0));
        tick();
        chk("basic_busy_c2", 32'(busy16), 32'(1));
        tick(); tick();
        in_valid = 1'b0;
        chk("basic_sv_c4", 32'(sv16), 32'(0));
        tick();
        chk("basic_sv_c5", 32'(sv16), 32'(1));
        chk("basic_busy_end", 32'(busy16), 32'(0));
        for (int k = 0; k < NUM_PE; k++) chk("basic_sad", 32'(sad16(k)), 32'(4 * k));
        tick();
        chk("basic_mv", 32'(mv16), 32'(1));
        chk("basic_min_sad", 32'(min_sad16), 32'(0));
        chk("basic_min_idx", 32'(min_idx16), 32'(0));

        // Tie with crt above pre: cells 3 and 7 at distance 2
        fill_chain(50);
        set_pre_all(10);
        pre_pixel_i[3*PIX_W +: PIX_W] = 8'd48;
        pre_pixel_i[7*PIX_W +: PIX_W] = 8'd48;
        acc_len  = 9'd1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("tie_sv", 32'(sv16), 32'(1));
        chk("tie_sad3", 32'(sad16(3)), 32'(2));
        chk("tie_sad7", 32'(sad16(7)), 32'(2));
        chk("tie_sad0", 32'(sad16(0)), 32'(40));
        tick();
        chk("tie_min_sad", 32'(min_sad16), 32'(2));
        chk("tie_min_idx", 32'(min_idx16), 32'(3));

        // Saturation: two back-to-back 256-beat blocks of 255 per beat
        fill_chain(255);
        set_pre_all(0);
        acc_len  = 9'd256;
        in_valid = 1'b1;
        pulses = 0; first_c = 0; second_c = 0;
        for (int n = 1; n <= 520; n++) begin
            tick();
            if (n == 512) in_valid = 1'b0;
            if (sv16) begin
                pulses++;
                if (pulses == 1) first_c = n;
                if (pulses == 2) second_c = n;
                chk("sat_sad16_c0", 32'(sad16(0)), 32'(65280));
                chk("sat_sad16_c15", 32'(sad16(15)), 32'(65280));
                chk("sat_sad12_c0", 32'(sad12(0)), 32'(4095));
                chk("sat_sv12", 32'(sv12), 32'(1));
            end
        end
        chk("sat_pulses", 32'(pulses), 32'(2));
        chk("sat_first_cycle", 32'(first_c), 32'(257));
        chk("sat_second_cycle", 32'(second_c), 32'(513));
        chk("sat_min_sad16", 32'(min_sad16), 32'(65280));
        chk("sat_min_sad12", 32'(min_sad12), 32'(4095));

        // Flush during a 4-beat block: no result, outputs keep old values
        set_pre_all(250);
        acc_len  = 9'd4;
        in_valid = 1'b1;
        tick();
        tick();
        chk("flush_busy_pre", 32'(busy16), 32'(1));
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_busy_post", 32'(busy16), 32'(0));
        seen = 0;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (sv16 || mv16) seen++;
        end
        chk("flush_no_valid", 32'(seen), 32'(0));
        chk("flush_sad_kept", 32'(sad16(0)), 32'(65280));
        chk("flush_min_kept", 32'(min_sad16), 32'(65280));

        // acc_len=0 acts as 1; a flush in the sad_valid cycle keeps min_valid
        set_pre_all(245);
        acc_len  = 9'd0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("len0_sv", 32'(sv16), 32'(1));
        chk("len0_busy", 32'(busy16), 32'(0));
        chk("len0_sad4", 32'(sad16(4)), 32'(10));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("len0_mv_after_flush", 32'(mv16), 32'(1));
        chk("len0_min_sad", 32'(min_sad16), 32'(10));
        chk("len0_min_idx", 32'(min_idx16), 32'(0));

        // Reset after beat 3 of 8 drops the block and clears the chain
        set_pre_all(250);
        acc_len  = 9'd8;
        in_valid = 1'b1;
        tick(); tick(); tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_busy", 32'(busy16), 32'(0));
        chk("mrst_sad_o", 32'(sad16(0)), 32'(0));
        chk("mrst_crt_o", 32'(crt_o16), 32'(0));
        seen = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (sv16) seen++;
        end
        chk("mrst_no_sv", 32'(seen), 32'(0));

        // Fresh 8-beat block against the cleared chain: 8 * 3 = 24
        set_pre_all(3);
        in_valid = 1'b1;
        for (int n = 0; n < 8; n++) tick();
        in_valid = 1'b0;
        chk("post_sv_early", 32'(sv16), 32'(0));
        tick();
        chk("post_sv", 32'(sv16), 32'(1));
        chk("post_sad9", 32'(sad16(9)), 32'(24));
        chk("post_sad12_9", 32'(sad12(9)), 32'(24));
        tick();
        chk("post_mv", 32'(mv16), 32'(1));
        chk("post_min_sad", 32'(min_sad16), 32'(24));
        chk("post_min_idx", 32'(min_idx16), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
